// File: rtl/queue_reader.sv
// Consumer-side pop controller: reserves local buffer space before each upstream pop
// so a stalled downstream never drops a response, and streams entries out in FIFO order.
module queue_reader #(
  parameter int WIDTH    = 8,
  parameter int BUF_BITS = 1
) (
  input  logic               clk0,
  input  logic               rst0,
  input  logic               flush,
  output logic               q_pop,
  input  logic               q_empty,
  input  logic               q_pop_resp,
  input  logic [WIDTH-1:0]   q_pop_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [BUF_BITS:0]  occupancy
);

  localparam int BUF_DEPTH = 2 ** BUF_BITS;
  localparam int PW        = BUF_BITS + 1;
  localparam int CW        = BUF_BITS + 2;

  logic [WIDTH-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             inflight;
  logic             discard;
  logic             deq;
  logic             capture;
  logic             full;
  logic [CW-1:0]    committed;

  assign occupancy = tail - head;
  assign full      = (tail[BUF_BITS] != head[BUF_BITS]) &&
                     (tail[BUF_BITS-1:0] == head[BUF_BITS-1:0]);
  assign out_valid = (occupancy != '0);
  assign out_data  = mem[head[BUF_BITS-1:0]];

  // A dequeue in the flush cycle is ignored; q_pop is forced low then anyway.
  assign deq = out_valid & out_ready & ~flush;

  // Slots already promised: buffered entries plus the response still in flight,
  // less the one leaving this cycle. One extra bit keeps the sum from wrapping.
  assign committed = {1'b0, occupancy} + CW'(inflight) - CW'(deq);
  assign q_pop     = ~rst0 & ~flush & ~q_empty & (committed < CW'(BUF_DEPTH));

  assign capture = inflight & q_pop_resp & ~discard & ~flush;

  always_ff @(posedge clk0) begin
    if (rst0) begin
      head     <= '0;
      tail     <= '0;
      inflight <= 1'b0;
      discard  <= 1'b0;
    end else begin
      inflight <= q_pop;
      discard  <= (flush & inflight) | (discard & inflight & ~q_pop_resp);
      if (flush) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (capture) tail <= tail + PW'(1);
        if (deq)     head <= head + PW'(1);
      end
    end
  end

  // NOTE: the entry storage is deliberately left out of reset; out_valid masks stale contents.
  always_ff @(posedge clk0) begin
    if (capture && !rst0) mem[tail[BUF_BITS-1:0]] <= q_pop_data;
  end

  a_resp_needs_pop: assert property (@(posedge clk0) disable iff (rst0)
    !(q_pop_resp && !inflight));

  a_no_overflow: assert property (@(posedge clk0) disable iff (rst0)
    !(capture && full && !deq));

endmodule

// File: tb/tb_queue_reader.sv
// Self-checking bench for queue_reader: upstream queue model, scoreboard FIFO,
// per-cycle vector table and hand-written flush / drain / reset sequences.
module tb_queue_reader;

  localparam int WIDTH    = 8;
  localparam int BUF_BITS = 1;
  localparam int DEPTH    = 2 ** BUF_BITS;

  logic              clk0 = 1'b0;
  logic              rst0;
  logic              flush;
  logic              q_pop;
  logic              q_empty;
  logic              q_pop_resp;
  logic [WIDTH-1:0]  q_pop_data;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [BUF_BITS:0] occupancy;

  queue_reader #(.WIDTH(WIDTH), .BUF_BITS(BUF_BITS)) dut (
    .clk0       (clk0),
    .rst0       (rst0),
    .flush      (flush),
    .q_pop      (q_pop),
    .q_empty    (q_empty),
    .q_pop_resp (q_pop_resp),
    .q_pop_data (q_pop_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .occupancy  (occupancy)
  );

  always #5 clk0 = ~clk0;

  typedef struct {
    bit         load;
    bit         rdy;
    bit         pop;
    bit         valid;
    int         occ;
    logic [7:0] data;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] up_q[$];
  logic [WIDTH-1:0] exp_q[$];
  bit               fake_nonempty = 1'b0;
  bit               prev_pop      = 1'b0;
  bit               stalled       = 1'b0;
  logic [WIDTH-1:0] stalled_data;
  bit               vec_en        = 1'b0;
  vec_t             cur;
  int               cur_idx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic update_empty();
    q_empty = (up_q.size() == 0) && !fake_nonempty;
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    up_q.push_back(v);
    update_empty();
  endtask

  // One clock cycle: sample and check at the falling edge, then advance the
  // upstream model just after the rising edge.
  task automatic step();
    bit               exp_pop;
    bit               deq;
    bit               s_pop;
    int               occ;
    logic [WIDTH-1:0] front;
    @(negedge clk0);
    s_pop   = q_pop;
    occ     = exp_q.size();
    deq     = (occ != 0) && out_ready && !flush && !rst0;
    exp_pop = !rst0 && !flush && !q_empty && (occ + int'(prev_pop) - int'(deq) < DEPTH);
    check("q_pop", q_pop, exp_pop);
    if (!rst0) begin
      check("occupancy", occupancy, occ);
      check("out_valid", out_valid, occ != 0);
      if (stalled && occ != 0) check("stall_hold", out_data, stalled_data);
      if (deq) begin
        front = exp_q.pop_front();
        check("out_data", out_data, front);
      end
      if (vec_en) begin
        check($sformatf("vec%0d_pop", cur_idx), q_pop, cur.pop);
        check($sformatf("vec%0d_valid", cur_idx), out_valid, cur.valid);
        check($sformatf("vec%0d_occ", cur_idx), occupancy, cur.occ);
        if (cur.valid) check($sformatf("vec%0d_data", cur_idx), out_data, cur.data);
      end
    end
    if (rst0 || flush) exp_q.delete();
    else if (prev_pop && q_pop_resp) exp_q.push_back(q_pop_data);
    stalled      = !rst0 && !flush && (occ != 0) && !out_ready;
    stalled_data = out_data;
    prev_pop     = exp_pop;

    @(posedge clk0);
    #1;
    if (s_pop && up_q.size() > 0) begin
      q_pop_resp = 1'b1;
      q_pop_data = up_q.pop_front();
    end else begin
      q_pop_resp = 1'b0;
      q_pop_data = '0;
    end
    fake_nonempty = 1'b0;
    update_empty();
  endtask

  function automatic vec_t mk(input bit ld, input bit rdy, input bit pop, input bit valid,
                              input int occ, input logic [7:0] data);
    vec_t v;
    v.load  = ld;
    v.rdy   = rdy;
    v.pop   = pop;
    v.valid = valid;
    v.occ   = occ;
    v.data  = data;
    return v;
  endfunction

  initial begin
    vec_t vecs[17];
    int   next_val;

    // Throughput: four entries, downstream always ready.
    vecs[0]  = mk(1, 1, 1, 0, 0, 8'h00);
    vecs[1]  = mk(0, 1, 1, 0, 0, 8'h00);
    vecs[2]  = mk(0, 1, 1, 1, 1, 8'h11);
    vecs[3]  = mk(0, 1, 1, 1, 1, 8'h22);
    vecs[4]  = mk(0, 1, 0, 1, 1, 8'h33);
    vecs[5]  = mk(0, 1, 0, 1, 1, 8'h44);
    vecs[6]  = mk(0, 1, 0, 0, 0, 8'h00);
    // Stall: only two pops fit, then release downstream.
    vecs[7]  = mk(1, 0, 1, 0, 0, 8'h00);
    vecs[8]  = mk(0, 0, 1, 0, 0, 8'h00);
    vecs[9]  = mk(0, 0, 0, 1, 1, 8'h11);
    vecs[10] = mk(0, 0, 0, 1, 2, 8'h11);
    vecs[11] = mk(0, 0, 0, 1, 2, 8'h11);
    vecs[12] = mk(0, 1, 1, 1, 2, 8'h11);
    vecs[13] = mk(0, 1, 1, 1, 1, 8'h22);
    vecs[14] = mk(0, 1, 0, 1, 1, 8'h33);
    vecs[15] = mk(0, 1, 0, 1, 1, 8'h44);
    vecs[16] = mk(0, 1, 0, 0, 0, 8'h00);

    rst0       = 1'b1;
    flush      = 1'b0;
    q_empty    = 1'b1;
    q_pop_resp = 1'b0;
    q_pop_data = '0;
    out_ready  = 1'b0;
    step();
    step();
    rst0 = 1'b0;

    // Idle after reset with an empty upstream queue.
    for (int i = 0; i < 5; i++) step();

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].load) begin
        load(8'h11); load(8'h22); load(8'h33); load(8'h44);
      end
      out_ready = vecs[i].rdy;
      cur       = vecs[i];
      cur_idx   = i;
      vec_en    = 1'b1;
      step();
      vec_en    = 1'b0;
    end

    // Pop issued while the queue drains elsewhere: no response, reservation released.
    out_ready = 1'b0;
    load(8'h55);
    step();
    step();
    fake_nonempty = 1'b1;
    update_empty();
    step();
    check("drain_no_resp", q_pop_resp, 1'b0);
    step();
    load(8'h66);
    #1;
    check("drain_occ_kept", occupancy, 1);
    check("drain_release_pop", q_pop, 1'b1);
    step();
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Flush with one entry buffered and one response arriving.
    out_ready = 1'b0;
    load(8'hA0); load(8'hA1); load(8'hA2);
    step();
    step();
    step();
    check("flush_pre_occ", occupancy, 2);
    out_ready = 1'b1;
    step();
    flush = 1'b1;
    #1;
    check("flush_q_pop", q_pop, 1'b0);
    check("flush_pre_valid", out_valid, 1'b1);
    step();
    flush = 1'b0;
    #1;
    check("flush_post_occ", occupancy, 0);
    check("flush_post_valid", out_valid, 1'b0);
    load(8'hB0);
    step();
    step();
    check("flush_next_valid", out_valid, 1'b1);
    check("flush_next_data", out_data, 8'hB0);
    step();
    step();

    // Random traffic with pointer wrap and a mid-stream reset.
    next_val = 8'h80;
    for (int i = 0; i < 40; i++) begin
      rst0 = (i == 20);
      if ($urandom_range(0, 2) != 0) begin
        load(next_val[7:0]);
        next_val++;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (i == 21) begin
        #1;
        check("post_reset_occ", occupancy, 0);
        check("post_reset_valid", out_valid, 1'b0);
      end
      step();
    end
    rst0      = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (up_q.size() == 0 && exp_q.size() == 0 && !prev_pop && !q_pop_resp) break;
      step();
    end
    step();
    check("final_occ", occupancy, 0);
    check("final_valid", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
